spart_rx_fifo: RTL
==================

// Module: spart_rx_fifo
// PURPOSE
//   Receive buffer between the SPART RX deserialiser and the processor bus interface.
//   Captures each completed byte (rx_rda/rx_data) into an 8-deep FIFO.
//   Acknowledges the deserialiser so it can clear rx_rda.
//   Serves data and status reads over iocs/iorw/ioaddr; sticky overrun/framing flags; rx_irq while non-empty.
// PARAMETERS
//   DW     8   data width in bits
//   DEPTH  8   FIFO entries; must be a power of two
//   AW     3   pointer width, log2(DEPTH); count is AW+1 bits
// PORTS
//   rx_clk        in   1    clock; all logic on posedge
//   rst           in   1    reset, asynchronous, active-high
//   rx_rda        in   1    byte ready from deserialiser; level, held until rx_ack seen
//   rx_data       in   DW   received byte; valid while rx_rda=1
//   rx_frame_err  in   1    stop-bit error pulse from deserialiser
//   rx_ack        out  1    1-cycle pulse: byte taken (or dropped on overrun)
//   iocs          in   1    chip select
//   iorw          in   1    1=read; writes to this block are ignored
//   ioaddr        in   2    00=data pop, 01=status, 10/11 read as 8'h00
//   rd_data       out  8    registered read data
//   rd_valid      out  1    1-cycle pulse, rd_data valid
//   rx_irq        out  1    1 while count != 0
// BEHAVIOUR
//   Reset: rx_ack=0, rd_data=8'h00, rd_valid=0, rx_irq=0.
//     Also wptr=rptr=count=0, ovf=0, ferr=0, capture FSM=IDLE.
//     Reset asserted mid-operation discards all FIFO contents immediately.
//   Capture FSM:
//     IDLE: if rx_rda=1 -> push request, rx_ack=1 next cycle, go WAIT_LOW.
//     WAIT_LOW: rx_ack=0; stay until rx_rda=0, then IDLE.
//     Result: exactly one push per rx_rda assertion, however long rx_rda is held.
//   Push: mem[wptr]<=rx_data, wptr++ (wraps DEPTH-1 -> 0), count++.
//   Overrun (push while full, no same-cycle pop): byte dropped, ovf<=1, rx_ack still pulses.
//   ferr<=1 on any cycle with rx_frame_err=1; no byte pushed for it.
//   Read strobe rd = iocs & iorw; rd_valid and rd_data update 1 cycle after rd (latency 1).
//   Data read (ioaddr=00):
//     Non-empty: rd_data=mem[rptr], rptr++ (wraps), count--.
//     Empty: rd_data=8'h00, no pointer or count change.
//   Status read (ioaddr=01): rd_data={ovf, ferr, empty, full, count[3:0]}.
//     ovf and ferr clear after the status is captured.
//     A set event in the same cycle wins: the flag stays 1.
//   Simultaneous push+pop:
//     Not empty: both occur, count unchanged.
//     Full: pop then push accepted, no overrun.
//     Empty: pop returns 8'h00, push stored, count=1.
//   rd held high for N cycles -> N independent reads (N pops for addr 00).
//   full=(count==DEPTH), empty=(count==0); rx_irq registered from next-state count.
// TESTING
//   1. Reset, pulse rx_rda with 8'hA5 held 5 cycles.
//      -> one rx_ack pulse, count=1, rx_irq=1.
//      -> data read: rd_data=A5 one cycle later, count=0, rx_irq=0.
//   2. Push 8'h01..8'h08 then 8'h09.
//      -> status=8'b1001_1000 (ovf, full, count 8); 09 dropped.
//      -> 8 pops return 01..08 in order; next status=8'h20 (empty, ovf cleared).
//   3. Empty data read -> rd_data=00, rd_valid=1, pointers unchanged.
//      Then 12 push/pop pairs -> pointer wrap, data order preserved.
//   4. Full FIFO, push and pop in same cycle -> no ovf, count stays 8, popped byte = oldest.
//   5. rx_frame_err pulse coinciding with a status read
//      -> read shows ferr=1, next status read still shows ferr=1, third read ferr=0.
//   6. Assert rst with 5 bytes queued and FSM in WAIT_LOW.
//      -> count=0, rx_irq=0, rd_data=00 immediately; new byte after release captured normally.

Source files
------------

// File: rtl/spart_rx_fifo.sv
// SPART receive buffer: captures deserialised bytes into a small FIFO and serves
// data/status reads to the processor bus, with sticky overrun and framing flags.
module spart_rx_fifo #(
    parameter int DW    = 8,
    parameter int DEPTH = 8,
    parameter int AW    = 3
) (
    input  logic          rx_clk,
    input  logic          rst,
    input  logic          rx_rda,
    input  logic [DW-1:0] rx_data,
    input  logic          rx_frame_err,
    output logic          rx_ack,
    input  logic          iocs,
    input  logic          iorw,
    input  logic [1:0]    ioaddr,
    output logic [7:0]    rd_data,
    output logic          rd_valid,
    output logic          rx_irq
);

    typedef enum logic {
        IDLE,
        WAIT_LOW
    } cap_state_t;

    localparam logic [AW:0] FULL_COUNT = (AW+1)'(DEPTH);

    cap_state_t    state;
    logic [DW-1:0] mem [DEPTH];
    logic [AW-1:0] wptr;
    logic [AW-1:0] rptr;
    logic [AW:0]   count;
    logic [AW:0]   count_next;
    logic          ovf;
    logic          ferr;

    logic          push_req;
    logic          push;
    logic          pop;
    logic          overrun;
    logic          rd;
    logic          stat_rd;
    logic          empty;
    logic          full;
    logic [7:0]    status_word;

    assign rd       = iocs & iorw;
    assign empty    = (count == '0);
    assign full     = (count == FULL_COUNT);
    assign push_req = (state == IDLE) && rx_rda;
    assign pop      = rd && (ioaddr == 2'b00) && !empty;
    // A same-cycle pop frees a slot, so a push into a full FIFO is still accepted.
    assign push     = push_req && (!full || pop);
    assign overrun  = push_req && full && !pop;
    assign stat_rd  = rd && (ioaddr == 2'b01);

    // Flags fold in same-cycle set events so a coinciding error is never lost.
    assign status_word = {ovf | overrun, ferr | rx_frame_err, empty, full, 4'(count)};

    always_comb begin
        count_next = count;
        case ({push, pop})
            2'b10:   count_next = count + 1'b1;
            2'b01:   count_next = count - 1'b1;
            default: count_next = count;
        endcase
    end

    always_ff @(posedge rx_clk) begin
        if (push) begin
            mem[wptr] <= rx_data;
        end
    end

    always_ff @(posedge rx_clk or posedge rst) begin
        if (rst) begin
            state    <= IDLE;
            rx_ack   <= 1'b0;
            wptr     <= '0;
            rptr     <= '0;
            count    <= '0;
            ovf      <= 1'b0;
            ferr     <= 1'b0;
            rd_data  <= 8'h00;
            rd_valid <= 1'b0;
            rx_irq   <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (rx_rda) begin
                        rx_ack <= 1'b1;
                        state  <= WAIT_LOW;
                    end else begin
                        rx_ack <= 1'b0;
                    end
                end
                WAIT_LOW: begin
                    rx_ack <= 1'b0;
                    if (!rx_rda) begin
                        state <= IDLE;
                    end
                end
                default: begin
                    rx_ack <= 1'b0;
                    state  <= IDLE;
                end
            endcase

            if (push) begin
                wptr <= wptr + 1'b1;
            end
            if (pop) begin
                rptr <= rptr + 1'b1;
            end
            count  <= count_next;
            rx_irq <= (count_next != '0);

            if (overrun) begin
                ovf <= 1'b1;
            end else if (stat_rd) begin
                ovf <= 1'b0;
            end
            if (rx_frame_err) begin
                ferr <= 1'b1;
            end else if (stat_rd) begin
                ferr <= 1'b0;
            end

            rd_valid <= rd;
            if (rd) begin
                case (ioaddr)
                    2'b00:   rd_data <= pop ? 8'(mem[rptr]) : 8'h00;
                    2'b01:   rd_data <= status_word;
                    default: rd_data <= 8'h00;
                endcase
            end
        end
    end

endmodule
